// File: rtl/lsu_pkg.sv
// Shared types and address map for the banked load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        Funct3B  = 3'b000,
        Funct3H  = 3'b001,
        Funct3W  = 3'b010,
        Funct3Bu = 3'b100,
        Funct3Hu = 3'b101
    } funct3_e;

    typedef enum logic [2:0] {
        RegionDmem,
        RegionLedr,
        RegionLedg,
        RegionHex,
        RegionLcd,
        RegionSw,
        RegionNone
    } region_e;

    localparam logic [31:0] IO_PAGE_MASK = 32'hFFFF_F000;
    localparam logic [31:0] LEDR_BASE    = 32'h1000_0000;
    localparam logic [31:0] LEDG_BASE    = 32'h1000_1000;
    localparam logic [31:0] LCD_BASE     = 32'h1000_F000;
    localparam logic [31:0] SW_BASE      = 32'h1001_0000;
    // HEX bank j lives in 4 KiB page HEX_PAGE0 + j.
    localparam logic [19:0] HEX_PAGE0    = 20'h1000_2;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte-enables/replication and load extract/extend.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_ld_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_st_word,
    output logic [31:0] o_ld_data,
    output logic        o_ok
);
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_half = i_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];
    assign w_byte = i_off[0] ? w_half[15:8] : w_half[7:0];

    always_comb begin
        o_be      = 4'b0000;
        o_st_word = 32'h0;
        o_ld_data = 32'h0;
        o_ok      = 1'b0;
        case (i_funct3)
            Funct3B, Funct3Bu: begin
                o_be      = 4'b0001 << i_off;
                o_st_word = {4{i_st_data[7:0]}};
                o_ld_data = (i_funct3 == Funct3B) ? {{24{w_byte[7]}}, w_byte}
                                                  : {24'h0, w_byte};
                o_ok      = 1'b1;
            end
            Funct3H, Funct3Hu: begin
                o_be      = i_off[1] ? 4'b1100 : 4'b0011;
                o_st_word = {2{i_st_data[15:0]}};
                o_ld_data = (i_funct3 == Funct3H) ? {{16{w_half[15]}}, w_half}
                                                  : {16'h0, w_half};
                o_ok      = ~i_off[0];
            end
            Funct3W: begin
                o_be      = 4'b1111;
                o_st_word = i_st_data;
                o_ld_data = i_ld_word;
                o_ok      = (i_off == 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_banked.sv
// Load/store unit with byte-enabled data memory and memory-mapped LED/HEX/LCD/switch I/O.
module lsu_banked
    import lsu_pkg::*;
#(
    parameter int unsigned DMEM_WORDS = 2048,
    parameter int unsigned N_HEX      = 8,
    parameter int unsigned SW_SYNC    = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_lsu_req,
    input  logic                 i_lsu_wren,
    input  logic [2:0]           i_funct3,
    input  logic [31:0]          i_lsu_addr,
    input  logic [31:0]          i_st_data,
    output logic [31:0]          o_ld_data,
    output logic                 o_ld_valid,
    output logic                 o_fault,
    output logic [31:0]          o_io_ledr,
    output logic [31:0]          o_io_ledg,
    output logic [31:0]          o_io_lcd,
    output logic [N_HEX*7-1:0]   o_io_hex,
    input  logic [31:0]          i_io_sw
);
    localparam int unsigned AW         = $clog2(DMEM_WORDS);
    localparam int unsigned N_BANK     = N_HEX / 4;
    localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);

    region_e       w_region;
    logic [19:0]   w_hex_page;
    logic [1:0]    w_bank;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_be;
    logic [31:0]   w_st_word;
    logic          w_align_ok;
    logic          w_f3_ok;
    logic          w_is_load;
    logic          w_is_store;
    logic          w_fault;
    logic          w_wr_en;
    logic [31:0]   w_io_word;
    logic [31:0]   w_raw_word;
    logic [31:0]   w_ld_ext;
    logic [31:0]   w_st_ld_unused;
    logic [3:0]    w_ld_be_unused;
    logic [31:0]   w_ld_st_unused;
    logic          w_ld_ok_unused;

    logic [31:0]              r_mem [DMEM_WORDS];
    logic [31:0]              r_dmem_q;
    logic [31:0]              r_ledr;
    logic [31:0]              r_ledg;
    logic [31:0]              r_lcd;
    logic [N_HEX*7-1:0]       r_hex;
    logic [SW_SYNC-1:0][31:0] r_sw_sync;
    logic                     r_ld_valid;
    logic                     r_fault;
    logic                     r_ld_dmem;
    logic [2:0]               r_ld_f3;
    logic [1:0]               r_ld_off;
    logic [31:0]              r_io_q;
    logic [31:0]              r_ld_hold;

    // Pages below HEX_PAGE0 wrap to large values, so one compare bounds both ends.
    assign w_hex_page = i_lsu_addr[31:12] - HEX_PAGE0;
    assign w_bank     = w_hex_page[1:0];
    assign w_idx      = i_lsu_addr[AW+1:2];

    always_comb begin
        w_region = RegionNone;
        if (i_lsu_addr < DMEM_BYTES) begin
            w_region = RegionDmem;
        end else if ((i_lsu_addr & IO_PAGE_MASK) == LEDR_BASE) begin
            w_region = RegionLedr;
        end else if ((i_lsu_addr & IO_PAGE_MASK) == LEDG_BASE) begin
            w_region = RegionLedg;
        end else if (w_hex_page < 20'(N_BANK)) begin
            w_region = RegionHex;
        end else if ((i_lsu_addr & IO_PAGE_MASK) == LCD_BASE) begin
            w_region = RegionLcd;
        end else if ((i_lsu_addr & IO_PAGE_MASK) == SW_BASE) begin
            w_region = RegionSw;
        end
    end

    lsu_lane_align u_st_align (
        .i_funct3  (i_funct3),
        .i_off     (i_lsu_addr[1:0]),
        .i_st_data (i_st_data),
        .i_ld_word (32'h0),
        .o_be      (w_be),
        .o_st_word (w_st_word),
        .o_ld_data (w_st_ld_unused),
        .o_ok      (w_align_ok)
    );

    assign w_is_load  = i_lsu_req & ~i_lsu_wren;
    assign w_is_store = i_lsu_req & i_lsu_wren;
    // Stores have no unsigned variants.
    assign w_f3_ok    = w_align_ok & ~(i_lsu_wren & i_funct3[2]);
    assign w_fault    = i_lsu_req & (~w_f3_ok | (w_region == RegionNone) |
                                     (i_lsu_wren & (w_region == RegionSw)));
    assign w_wr_en    = w_is_store & ~w_fault;

    always_ff @(posedge i_clk) begin
        if (w_wr_en && (w_region == RegionDmem)) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_st_word[8*k +: 8];
                end
            end
        end
        if (w_is_load && (w_region == RegionDmem)) begin
            r_dmem_q <= r_mem[w_idx];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ledr <= '0;
            r_ledg <= '0;
            r_lcd  <= '0;
            r_hex  <= '0;
        end else if (w_wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    case (w_region)
                        RegionLedr: r_ledr[8*k +: 8] <= w_st_word[8*k +: 8];
                        RegionLedg: r_ledg[8*k +: 8] <= w_st_word[8*k +: 8];
                        RegionLcd:  r_lcd[8*k +: 8]  <= w_st_word[8*k +: 8];
                        RegionHex:  r_hex[(4*int'(w_bank) + k)*7 +: 7] <= w_st_word[8*k +: 7];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sw_sync <= '0;
        end else begin
            r_sw_sync[0] <= i_io_sw;
            for (int i = 1; i < int'(SW_SYNC); i++) begin
                r_sw_sync[i] <= r_sw_sync[i-1];
            end
        end
    end

    always_comb begin
        w_io_word = 32'h0;
        case (w_region)
            RegionLedr: w_io_word = r_ledr;
            RegionLedg: w_io_word = r_ledg;
            RegionLcd:  w_io_word = r_lcd;
            RegionSw:   w_io_word = r_sw_sync[SW_SYNC-1];
            RegionHex: begin
                for (int k = 0; k < 4; k++) begin
                    w_io_word[8*k +: 8] = {1'b0, r_hex[(4*int'(w_bank) + k)*7 +: 7]};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ld_valid <= 1'b0;
            r_fault    <= 1'b0;
            r_ld_dmem  <= 1'b0;
            r_ld_f3    <= 3'b000;
            r_ld_off   <= 2'b00;
            r_io_q     <= '0;
            r_ld_hold  <= '0;
        end else begin
            r_ld_valid <= w_is_load;
            r_fault    <= w_fault;
            r_ld_hold  <= o_ld_data;
            if (w_is_load) begin
                r_ld_dmem <= (w_region == RegionDmem);
                r_ld_f3   <= i_funct3;
                r_ld_off  <= i_lsu_addr[1:0];
                r_io_q    <= w_io_word;
            end
        end
    end

    assign w_raw_word = r_ld_dmem ? r_dmem_q : r_io_q;

    lsu_lane_align u_ld_align (
        .i_funct3  (r_ld_f3),
        .i_off     (r_ld_off),
        .i_st_data (32'h0),
        .i_ld_word (w_raw_word),
        .o_be      (w_ld_be_unused),
        .o_st_word (w_ld_st_unused),
        .o_ld_data (w_ld_ext),
        .o_ok      (w_ld_ok_unused)
    );

    // Idle cycles replay the last presented value so the output holds.
    assign o_ld_data  = r_ld_valid ? (r_fault ? 32'h0 : w_ld_ext) : r_ld_hold;
    assign o_ld_valid = r_ld_valid;
    assign o_fault    = r_fault;
    assign o_io_ledr  = r_ledr;
    assign o_io_ledg  = r_ledg;
    assign o_io_lcd   = r_lcd;
    assign o_io_hex   = r_hex;

endmodule

// File: tb/tb_lsu_banked.sv
// Directed bench for lsu_banked: memory lanes, MMIO, faults, switch sync and async reset.
module tb_lsu_banked;
    localparam int unsigned N_HEX   = 8;
    localparam int unsigned SW_SYNC = 2;

    localparam logic [2:0] F3B  = 3'b000;
    localparam logic [2:0] F3H  = 3'b001;
    localparam logic [2:0] F3W  = 3'b010;
    localparam logic [2:0] F3BU = 3'b100;
    localparam logic [2:0] F3HU = 3'b101;

    localparam logic [N_HEX*7-1:0] HEX_EXP = {7'h7F, 7'h3F, 7'h06, 7'h01, 28'h0};

    logic                i_clk = 1'b0;
    logic                i_reset;
    logic                i_lsu_req;
    logic                i_lsu_wren;
    logic [2:0]          i_funct3;
    logic [31:0]         i_lsu_addr;
    logic [31:0]         i_st_data;
    logic [31:0]         i_io_sw;
    logic [31:0]         o_ld_data;
    logic                o_ld_valid;
    logic                o_fault;
    logic [31:0]         o_io_ledr;
    logic [31:0]         o_io_ledg;
    logic [31:0]         o_io_lcd;
    logic [N_HEX*7-1:0]  o_io_hex;

    int n_pass  = 0;
    int n_total = 0;

    always #5 i_clk = ~i_clk;

    lsu_banked #(
        .DMEM_WORDS (2048),
        .N_HEX      (N_HEX),
        .SW_SYNC    (SW_SYNC)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_lsu_req  (i_lsu_req),
        .i_lsu_wren (i_lsu_wren),
        .i_funct3   (i_funct3),
        .i_lsu_addr (i_lsu_addr),
        .i_st_data  (i_st_data),
        .o_ld_data  (o_ld_data),
        .o_ld_valid (o_ld_valid),
        .o_fault    (o_fault),
        .o_io_ledr  (o_io_ledr),
        .o_io_ledg  (o_io_ledg),
        .o_io_lcd   (o_io_lcd),
        .o_io_hex   (o_io_hex),
        .i_io_sw    (i_io_sw)
    );

    // Presents one request for a single cycle; returns 1 time unit into the result cycle.
    task automatic drive(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data);
        i_lsu_req  = 1'b1;
        i_lsu_wren = wren;
        i_funct3   = f3;
        i_lsu_addr = addr;
        i_st_data  = data;
        @(posedge i_clk);
        #1;
        i_lsu_req  = 1'b0;
        i_lsu_wren = 1'b0;
    endtask

    task automatic idle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_lsu_req = 1'b0; i_lsu_wren = 1'b0; i_funct3 = 3'b000;
        i_lsu_addr = 32'h0; i_st_data = 32'h0; i_io_sw = 32'h0;
        repeat (2) @(posedge i_clk);
        #1;
        n_total++;
        if ({o_ld_valid, o_fault, o_ld_data} !== 34'h0)
            $display("FAIL reset_ld: got %h want 0", {o_ld_valid, o_fault, o_ld_data});
        else n_pass++;
        n_total++;
        if ({o_io_ledr, o_io_ledg, o_io_lcd, o_io_hex} !== '0)
            $display("FAIL reset_io: got %h want 0", {o_io_ledr, o_io_ledg, o_io_lcd, o_io_hex});
        else n_pass++;
        i_reset = 1'b0;
        drive(1'b0, F3W, 32'h1000_0000, 32'h0);
        n_total++;
        if ({o_ld_valid, o_fault, o_ld_data} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL first_req_after_reset: got %h want %h",
                     {o_ld_valid, o_fault, o_ld_data}, {1'b1, 1'b0, 32'h0});
        else n_pass++;
    endtask

    task automatic test_dmem();
        logic [2:0]  f3_t  [5];
        logic [31:0] adr_t [5];
        logic [31:0] exp_t [5];
        f3_t  = '{F3B, F3BU, F3H, F3HU, F3W};
        adr_t = '{32'h13, 32'h12, 32'h10, 32'h12, 32'h10};
        exp_t = '{32'hFFFF_FFDE, 32'h0000_00AD, 32'hFFFF_BEEF, 32'h0000_DEAD, 32'hDEAD_BEEF};
        drive(1'b1, F3W, 32'h10, 32'hDEAD_BEEF);
        n_total++;
        if ({o_ld_valid, o_fault} !== 2'b00)
            $display("FAIL store_no_valid: got %b want 00", {o_ld_valid, o_fault});
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, f3_t[i], adr_t[i], 32'h0);
            n_total++;
            if ({o_ld_valid, o_fault, o_ld_data} !== {1'b1, 1'b0, exp_t[i]})
                $display("FAIL dmem_load_%0d: got %h want %h", i,
                         {o_ld_valid, o_fault, o_ld_data}, {1'b1, 1'b0, exp_t[i]});
            else n_pass++;
        end
        drive(1'b1, F3B, 32'h11, 32'h0000_0055);
        drive(1'b0, F3W, 32'h10, 32'h0);
        n_total++;
        if ({o_ld_valid, o_fault, o_ld_data} !== {1'b1, 1'b0, 32'hDEAD_55EF})
            $display("FAIL sb_then_lw: got %h want %h",
                     {o_ld_valid, o_fault, o_ld_data}, {1'b1, 1'b0, 32'hDEAD_55EF});
        else n_pass++;
        idle();
        n_total++;
        if ({o_ld_valid, o_fault, o_ld_data} !== {1'b0, 1'b0, 32'hDEAD_55EF})
            $display("FAIL idle_hold: got %h want %h",
                     {o_ld_valid, o_fault, o_ld_data}, {1'b0, 1'b0, 32'hDEAD_55EF});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, F3W, 32'h20, 32'h0102_0304);
        drive(1'b0, F3W, 32'h20, 32'h0);
        n_total++;
        if ({o_ld_valid, o_ld_data} !== {1'b1, 32'h0102_0304})
            $display("FAIL b2b_lw: got %h want %h", {o_ld_valid, o_ld_data}, {1'b1, 32'h0102_0304});
        else n_pass++;
        drive(1'b1, F3H, 32'h22, 32'h0000_BEEF);
        drive(1'b0, F3B, 32'h23, 32'h0);
        n_total++;
        if ({o_ld_valid, o_ld_data} !== {1'b1, 32'hFFFF_FFBE})
            $display("FAIL b2b_lb: got %h want %h", {o_ld_valid, o_ld_data}, {1'b1, 32'hFFFF_FFBE});
        else n_pass++;
        drive(1'b0, F3W, 32'h20, 32'h0);
        n_total++;
        if ({o_ld_valid, o_ld_data} !== {1'b1, 32'hBEEF_0304})
            $display("FAIL b2b_lw2: got %h want %h", {o_ld_valid, o_ld_data}, {1'b1, 32'hBEEF_0304});
        else n_pass++;
    endtask

    task automatic test_mmio();
        logic [2:0]  f3_t  [7];
        logic [31:0] adr_t [7];
        logic [31:0] exp_t [7];
        f3_t  = '{F3W, F3B, F3HU, F3H, F3BU, F3B, F3W};
        adr_t = '{32'h1000_3000, 32'h1000_0003, 32'h1000_F002, 32'h1000_F002,
                  32'h1000_1003, 32'h1000_1003, 32'h1000_2000};
        exp_t = '{32'h7F3F_0601, 32'h0000_0012, 32'h0000_CAFE, 32'hFFFF_CAFE,
                  32'h0000_00AB, 32'hFFFF_FFAB, 32'h0000_0000};
        drive(1'b1, F3W, 32'h1000_3000, 32'h7F3F_0601);
        n_total++;
        if ({o_io_ledr, o_io_ledg, o_io_lcd, o_io_hex} !== {96'h0, HEX_EXP})
            $display("FAIL hex_store: got %h want %h",
                     {o_io_ledr, o_io_ledg, o_io_lcd, o_io_hex}, {96'h0, HEX_EXP});
        else n_pass++;
        drive(1'b1, F3H, 32'h1000_0002, 32'h0000_1234);
        drive(1'b1, F3B, 32'h1000_1003, 32'h0000_00AB);
        drive(1'b1, F3W, 32'h1000_F000, 32'hCAFE_F00D);
        n_total++;
        if ({o_io_ledr, o_io_ledg, o_io_lcd} !== {32'h1234_0000, 32'hAB00_0000, 32'hCAFE_F00D})
            $display("FAIL led_lcd_store: got %h want %h", {o_io_ledr, o_io_ledg, o_io_lcd},
                     {32'h1234_0000, 32'hAB00_0000, 32'hCAFE_F00D});
        else n_pass++;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, f3_t[i], adr_t[i], 32'h0);
            n_total++;
            if ({o_ld_valid, o_fault, o_ld_data} !== {1'b1, 1'b0, exp_t[i]})
                $display("FAIL mmio_load_%0d: got %h want %h", i,
                         {o_ld_valid, o_fault, o_ld_data}, {1'b1, 1'b0, exp_t[i]});
            else n_pass++;
        end
    endtask

    task automatic test_faults();
        drive(1'b1, F3W, 32'h0, 32'h1122_3344);
        drive(1'b0, F3W, 32'h2, 32'h0);
        n_total++;
        if ({o_ld_valid, o_fault, o_ld_data} !== {1'b1, 1'b1, 32'h0})
            $display("FAIL lw_misaligned: got %h want %h",
                     {o_ld_valid, o_fault, o_ld_data}, {1'b1, 1'b1, 32'h0});
        else n_pass++;
        drive(1'b1, F3H, 32'h1, 32'h0000_FFFF);
        n_total++;
        if ({o_ld_valid, o_fault} !== 2'b01)
            $display("FAIL sh_misaligned: got %b want 01", {o_ld_valid, o_fault});
        else n_pass++;
        drive(1'b0, F3W, 32'h0, 32'h0);
        n_total++;
        if ({o_ld_valid, o_fault, o_ld_data} !== {1'b1, 1'b0, 32'h1122_3344})
            $display("FAIL mem_unchanged: got %h want %h",
                     {o_ld_valid, o_fault, o_ld_data}, {1'b1, 1'b0, 32'h1122_3344});
        else n_pass++;
        drive(1'b1, F3W, 32'h2000_0000, 32'h1);
        n_total++;
        if ({o_ld_valid, o_fault} !== 2'b01)
            $display("FAIL sw_unmapped: got %b want 01", {o_ld_valid, o_fault});
        else n_pass++;
        drive(1'b1, F3W, 32'h1001_0000, 32'h1);
        n_total++;
        if ({o_ld_valid, o_fault} !== 2'b01)
            $display("FAIL sw_to_switches: got %b want 01", {o_ld_valid, o_fault});
        else n_pass++;
        drive(1'b1, F3W, 32'h1000_4000, 32'h1234_5678);
        n_total++;
        if ({o_fault, o_io_hex} !== {1'b1, HEX_EXP})
            $display("FAIL hex_bank_oob_store: got %h want %h", {o_fault, o_io_hex}, {1'b1, HEX_EXP});
        else n_pass++;
        drive(1'b0, F3W, 32'h1000_4000, 32'h0);
        n_total++;
        if ({o_ld_valid, o_fault, o_ld_data} !== {1'b1, 1'b1, 32'h0})
            $display("FAIL hex_bank_oob_load: got %h want %h",
                     {o_ld_valid, o_fault, o_ld_data}, {1'b1, 1'b1, 32'h0});
        else n_pass++;
        drive(1'b0, 3'b011, 32'h0, 32'h0);
        n_total++;
        if ({o_ld_valid, o_fault, o_ld_data} !== {1'b1, 1'b1, 32'h0})
            $display("FAIL illegal_funct3: got %h want %h",
                     {o_ld_valid, o_fault, o_ld_data}, {1'b1, 1'b1, 32'h0});
        else n_pass++;
        idle();
        n_total++;
        if ({o_ld_valid, o_fault} !== 2'b00)
            $display("FAIL fault_one_cycle: got %b want 00", {o_ld_valid, o_fault});
        else n_pass++;
        drive(1'b0, F3H, 32'h1000_0001, 32'h0);
        n_total++;
        if ({o_ld_valid, o_fault, o_ld_data} !== {1'b1, 1'b1, 32'h0})
            $display("FAIL lh_misaligned_io: got %h want %h",
                     {o_ld_valid, o_fault, o_ld_data}, {1'b1, 1'b1, 32'h0});
        else n_pass++;
    endtask

    task automatic test_switches();
        i_io_sw = 32'hA5A5_A5A5;
        repeat (SW_SYNC - 1) idle();
        drive(1'b0, F3W, 32'h1001_0000, 32'h0);
        n_total++;
        if ({o_ld_valid, o_fault, o_ld_data} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL sw_early: got %h want %h",
                     {o_ld_valid, o_fault, o_ld_data}, {1'b1, 1'b0, 32'h0});
        else n_pass++;
        drive(1'b0, F3W, 32'h1001_0000, 32'h0);
        n_total++;
        if ({o_ld_valid, o_fault, o_ld_data} !== {1'b1, 1'b0, 32'hA5A5_A5A5})
            $display("FAIL sw_synced: got %h want %h",
                     {o_ld_valid, o_fault, o_ld_data}, {1'b1, 1'b0, 32'hA5A5_A5A5});
        else n_pass++;
    endtask

    task automatic test_reset_midload();
        i_lsu_req  = 1'b1;
        i_lsu_wren = 1'b0;
        i_funct3   = F3W;
        i_lsu_addr = 32'h10;
        #2;
        i_reset = 1'b1;
        #1;
        n_total++;
        if ({o_ld_valid, o_fault, o_ld_data} !== 34'h0)
            $display("FAIL midload_reset_ld: got %h want 0", {o_ld_valid, o_fault, o_ld_data});
        else n_pass++;
        n_total++;
        if ({o_io_ledr, o_io_ledg, o_io_lcd, o_io_hex} !== '0)
            $display("FAIL midload_reset_io: got %h want 0",
                     {o_io_ledr, o_io_ledg, o_io_lcd, o_io_hex});
        else n_pass++;
        @(posedge i_clk);
        #1;
        i_lsu_req = 1'b0;
        i_reset   = 1'b0;
        idle();
        n_total++;
        if ({o_ld_valid, o_fault} !== 2'b00)
            $display("FAIL dropped_after_reset: got %b want 00", {o_ld_valid, o_fault});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_dmem();
        test_back_to_back();
        test_mmio();
        test_faults();
        test_switches();
        test_reset_midload();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
